// File: rtl/serial_pkg.sv
// serial_pkg: shared constants for the serial device (receiver, transmitter, FIFOs).
package serial_pkg;
    localparam int BYTE_W        = 8;
    localparam int RX_FIFO_DEPTH = 8;
endpackage

// File: rtl/serial_rx_fifo_if.sv
// serial_rx_fifo_if: receiver-side capture and consumer read port of the receive FIFO.
interface serial_rx_fifo_if
    import serial_pkg::*;
#(
    parameter int DEPTH = RX_FIFO_DEPTH
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [BYTE_W-1:0] rx_data;
    logic              rx_finished;
    logic              rd_en;
    logic              clr_overflow;
    logic [BYTE_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic [PTR_W:0]    count;
    logic              overflow;
    modport master (
        output rx_data, rx_finished, rd_en, clr_overflow,
        input  rd_data, empty, full, count, overflow
    );
    modport slave (
        input  rx_data, rx_finished, rd_en, clr_overflow,
        output rd_data, empty, full, count, overflow
    );
endinterface

// File: rtl/serial_rx_fifo_sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with explicit count; a pop on a full queue frees room
// for a simultaneous push.
module sync_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push_i,
    input  logic           pop_i,
    input  logic [W-1:0]   wdata_i,
    output logic [W-1:0]   rdata_o,
    output logic           empty_o,
    output logic           full_o,
    output logic [PTR_W:0] count_o
);
    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             pop, wr;

    assign empty_o = count_q == '0;
    assign full_o  = count_q == (PTR_W+1)'(DEPTH);
    assign count_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        pop      = pop_i & ~empty_o;
        wr       = push_i & (~full_o | pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(wr);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + (PTR_W+1)'(wr) - (PTR_W+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && wr) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: captures a byte on each rising edge of the receiver's finished level and
// queues it; drops bytes into a sticky overflow flag since the receiver cannot be stalled.
module serial_rx_fifo
    import serial_pkg::*;
#(
    parameter int DEPTH = RX_FIFO_DEPTH
) (
    input logic             clk,
    input logic             reset,
    serial_rx_fifo_if.slave bus
);
    logic fin_q, push, drop;
    logic overflow_q, overflow_d;

    // fin_q resets high so a receiver idling with finished asserted does not push.
    always_comb begin
        push       = bus.rx_finished & ~fin_q;
        drop       = push & bus.full & ~bus.rd_en;
        overflow_d = drop | (overflow_q & ~bus.clr_overflow);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fin_q      <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            fin_q      <= bus.rx_finished;
            overflow_q <= overflow_d;
        end
    end

    assign bus.overflow = overflow_q;

    sync_fifo #(.W(BYTE_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (bus.rd_en),
        .wdata_i (bus.rx_data),
        .rdata_o (bus.rd_data),
        .empty_o (bus.empty),
        .full_o  (bus.full),
        .count_o (bus.count)
    );
endmodule

// File: tb/tb_serial_rx_fifo.sv
// tb_serial_rx_fifo: scoreboard bench; expected bytes are queued when a finished edge is driven
// and compared against rd_data as the consumer pops them.
module tb_serial_rx_fifo;
    import serial_pkg::*;
    localparam int DEPTH = RX_FIFO_DEPTH;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] mdl[$];
    bit         mdl_ovf = 0;
    bit         prev_fin = 1;

    serial_rx_fifo_if #(.DEPTH(DEPTH)) bus();
    serial_rx_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(bus.count), 32'(mdl.size()));
        check({tag, ".empty"}, 32'(bus.empty), 32'(mdl.size() == 0));
        check({tag, ".full"}, 32'(bus.full), 32'(mdl.size() == DEPTH));
        check({tag, ".ovf"}, 32'(bus.overflow), 32'(mdl_ovf));
        check({tag, ".rd"}, 32'(bus.rd_data), mdl.size() > 0 ? 32'(mdl[0]) : 32'h0);
    endtask

    // Drive one clock of stimulus, then advance the scoreboard and compare.
    task automatic cycle(input bit fin, input logic [7:0] d, input bit rd, input bit clr,
                         input string tag);
        bit push, pop, drop;
        bus.rx_finished  = fin;
        bus.rx_data      = d;
        bus.rd_en        = rd;
        bus.clr_overflow = clr;
        push = fin & ~prev_fin;
        pop  = rd && mdl.size() > 0;
        if (pop) check({tag, ".pop"}, 32'(bus.rd_data), 32'(mdl[0]));
        @(posedge clk);
        #1;
        prev_fin = fin;
        if (pop) void'(mdl.pop_front());
        drop = push && mdl.size() == DEPTH;
        if (push && !drop) mdl.push_back(d);
        if (drop) mdl_ovf = 1;
        else if (clr) mdl_ovf = 0;
        check_state(tag);
    endtask

    task automatic pulse(input logic [7:0] d);
        cycle(1, d, 0, 0, "push");
        cycle(0, d, 0, 0, "gap");
    endtask

    task automatic do_reset();
        bus.rx_finished = 0;
        bus.rd_en       = 0;
        reset = 0;
        @(posedge clk);
        #1;
        mdl.delete();
        mdl_ovf  = 0;
        prev_fin = 1;
        check_state("rst");
        reset = 1;
    endtask

    initial begin
        bus.rx_finished  = 1;
        bus.rx_data      = 8'h00;
        bus.rd_en        = 0;
        bus.clr_overflow = 0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        check("reset.rd00", 32'(bus.rd_data), 32'h0);
        reset = 1;
        repeat (3) cycle(1, 8'h12, 0, 0, "idlehi");
        check("idlehi.count", 32'(bus.count), 32'd0);
        cycle(0, 8'h00, 0, 0, "idlelo");

        pulse(8'h41);
        pulse(8'h42);
        pulse(8'h43);
        check("abc.count", 32'(bus.count), 32'd3);
        check("abc.rd", 32'(bus.rd_data), 32'h41);
        repeat (3) cycle(0, 8'h00, 1, 0, "abcpop");
        check("abc.rd00", 32'(bus.rd_data), 32'h0);
        check("abc.empty", 32'(bus.empty), 32'd1);

        for (int i = 0; i < DEPTH; i++) pulse(8'(i));
        check("fill.full", 32'(bus.full), 32'd1);
        pulse(8'hFF);
        check("drop.ovf", 32'(bus.overflow), 32'd1);
        check("drop.count", 32'(bus.count), 32'd8);
        repeat (DEPTH) cycle(0, 8'h00, 1, 0, "drain");
        check("drain.empty", 32'(bus.empty), 32'd1);
        cycle(0, 8'h00, 0, 1, "clr");
        check("clr.ovf", 32'(bus.overflow), 32'd0);

        for (int i = 0; i < DEPTH; i++) pulse(8'(i));
        cycle(1, 8'hAA, 1, 0, "fullpp");
        check("fullpp.count", 32'(bus.count), 32'd8);
        check("fullpp.ovf", 32'(bus.overflow), 32'd0);
        check("fullpp.rd", 32'(bus.rd_data), 32'h01);
        cycle(0, 8'h00, 0, 0, "gap");
        repeat (DEPTH - 1) cycle(0, 8'h00, 1, 0, "drainaa");
        check("aa.last", 32'(bus.rd_data), 32'hAA);
        cycle(0, 8'h00, 1, 0, "popaa");

        repeat (20) cycle(1, 8'h55, 0, 0, "hold");
        check("hold.count", 32'(bus.count), 32'd1);
        cycle(0, 8'h00, 1, 0, "pop55");
        repeat (2) cycle(0, 8'h00, 1, 0, "emptyrd");
        check("emptyrd.count", 32'(bus.count), 32'd0);

        for (int i = 0; i < 3 * DEPTH; i++) begin
            cycle(1, 8'(8'h60 + i), 0, 0, "wrap");
            cycle(0, 8'h00, i % 2 == 0, 0, "wrap");
        end
        repeat (2 * DEPTH) cycle(0, 8'h00, 1, 0, "wrapdrain");

        for (int i = 0; i < 5; i++) pulse(8'(8'h30 + i));
        check("pre.count", 32'(bus.count), 32'd5);
        do_reset();
        check("rst.count", 32'(bus.count), 32'd0);
        check("rst.empty", 32'(bus.empty), 32'd1);
        cycle(0, 8'h00, 0, 0, "post");
        pulse(8'h99);
        check("post.rd", 32'(bus.rd_data), 32'h99);
        cycle(0, 8'h00, 1, 0, "pop99");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
